// File: rtl/scan_ctrl_pkg.sv
// Shared definitions for the scan chain controller: FSM state encoding and
// the legal range of the chain length.
package scan_ctrl_pkg;

  localparam int CHAIN_LEN_MIN = 2;
  localparam int CHAIN_LEN_MAX = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CAPTURE,
    UNLOAD,
    FINISH
  } state_t;

  // True when a chain length can be handled by the controller.
  function automatic bit chain_len_ok(input int n);
    return (n >= CHAIN_LEN_MIN) && (n <= CHAIN_LEN_MAX);
  endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load shift register. Shifts toward the MSB: serial data enters at
// bit 0 and leaves from bit WIDTH-1. Load has priority over shift.
module scan_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_out
);

  logic [WIDTH-1:0] q;

  // Register update: synchronous clear, then parallel load, then shift.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, exactly like the scan chain flops sharing this clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= par_in;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], ser_in};
    end
  end

  assign par_out = q;
  assign ser_out = q[WIDTH-1];

endmodule

// File: rtl/scan_chain_ctrl.sv
// Load / capture / unload controller for a serial chain of scan flops.
// SE and SI are flop outputs so the chain never sees a combinational path from
// START or SO. SI is taken straight from the MSB of the pattern register, which
// fills with zeros while shifting, so it reads 0 outside the LOAD window.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT,
  output logic                 SE,
  output logic                 SI,
  input  logic                 SO,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP
);

  if (!chain_len_ok(CHAIN_LEN)) begin : g_len_check
    $error("scan_chain_ctrl: CHAIN_LEN outside the supported range");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             accept;
  logic             pat_so;
  logic [CHAIN_LEN-1:0] pat_unused_q;
  logic             resp_unused_so;

  assign cnt_last = (cnt == CNT_W'(CHAIN_LEN - 1));
  assign accept   = (state == IDLE) && START;

  // Pattern register: captures PAT on acceptance, shifts out MSB first in LOAD.
  scan_shift_reg #(
    .WIDTH (CHAIN_LEN)
  ) u_pat_reg (
    .clk     (CLK),
    .rst     (RST),
    .load    (accept),
    .shift   (state == LOAD),
    .par_in  (PAT),
    .ser_in  (1'b0),
    .par_out (pat_unused_q),
    .ser_out (pat_so)
  );

  assign SI = pat_so;

  // Response register: collects SO on every UNLOAD edge, first bit ends at MSB.
  scan_shift_reg #(
    .WIDTH (CHAIN_LEN)
  ) u_resp_reg (
    .clk     (CLK),
    .rst     (RST),
    .load    (1'b0),
    .shift   (state == UNLOAD),
    .par_in  ('0),
    .ser_in  (SO),
    .par_out (RESP),
    .ser_out (resp_unused_so)
  );

  // Sequencer: state, shift counter and the registered SE/BUSY/DONE outputs.
  // SE changes on the edge that enters a state, so the chain acts on it one
  // edge later; the counter exit points are placed to give exactly CHAIN_LEN
  // chain shifts in each of LOAD and UNLOAD.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      SE    <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            state <= LOAD;
            cnt   <= '0;
            SE    <= 1'b1;
            BUSY  <= 1'b1;
          end
        end
        LOAD: begin
          cnt <= cnt + 1'b1;
          if (cnt_last) begin
            state <= CAPTURE;
            SE    <= 1'b0;
          end
        end
        CAPTURE: begin
          state <= UNLOAD;
          cnt   <= '0;
          SE    <= 1'b1;
        end
        UNLOAD: begin
          cnt <= cnt + 1'b1;
          if (cnt_last) begin
            state <= FINISH;
            SE    <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          SE    <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: an 8-flop and a 2-flop build, each driving a
// behavioural scan chain whose functional D is either ~Q or Q. Expected
// responses and DONE cycles are queued when START is issued and checked by
// per-DUT monitors whenever DONE is seen.
module tb_scan_chain_ctrl;

  typedef struct {
    logic [7:0] resp;
    int         done_e;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start8, se8, si8, so8, busy8, done8;
  logic [7:0] pat8, resp8;
  logic       start2, se2, si2, so2, busy2, done2;
  logic [1:0] pat2, resp2;

  logic [7:0] chain8 = '0;
  logic [1:0] chain2 = '0;
  logic       inv8 = 1'b0;
  logic       inv2 = 1'b0;

  int   ecnt   = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t q8[$];
  exp_t q2[$];

  scan_chain_ctrl #(.CHAIN_LEN(8)) u_dut8 (
    .CLK(clk), .RST(rst), .START(start8), .PAT(pat8), .SE(se8), .SI(si8),
    .SO(so8), .BUSY(busy8), .DONE(done8), .RESP(resp8)
  );

  scan_chain_ctrl #(.CHAIN_LEN(2)) u_dut2 (
    .CLK(clk), .RST(rst), .START(start2), .PAT(pat2), .SE(se2), .SI(si2),
    .SO(so2), .BUSY(busy2), .DONE(done2), .RESP(resp2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: after the k-th rising edge ecnt == k.
  always @(posedge clk) ecnt <= ecnt + 1;

  // Behavioural chains: scan mux SE ? SI : D, with D = ~Q or D = Q.
  always @(posedge clk) chain8 <= se8 ? {chain8[6:0], si8} : (inv8 ? ~chain8 : chain8);
  always @(posedge clk) chain2 <= se2 ? {chain2[0], si2} : (inv2 ? ~chain2 : chain2);
  assign so8 = chain8[7];
  assign so2 = chain2[1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: every DONE must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        check("dut8_spurious_done", 64'(done8), 64'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("dut8_resp", 64'(resp8), 64'(e.resp));
        check("dut8_done_cycle", 64'(ecnt), 64'(e.done_e));
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) begin
        check("dut2_spurious_done", 64'(done2), 64'd0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        check("dut2_resp", 64'(resp2), 64'(e.resp));
        check("dut2_done_cycle", 64'(ecnt), 64'(e.done_e));
      end
    end
  end

  // One 8-flop sequence. Cycle c (value seen before edge a+c) is sampled at
  // the negedge after edge a+c-1. Optional extra START pulses at pulse_a/b.
  task automatic seq8(input logic [7:0] pat, input logic inv, input int pulse_a, input int pulse_b);
    int          a;
    logic [18:0] se_v, busy_v, se_exp, busy_exp;
    logic [7:0]  si_v;
    logic        si_unl;
    se_v   = '0;
    busy_v = '0;
    si_v   = '0;
    si_unl = 1'b0;
    inv8   = inv;
    pat8   = pat;
    start8 = 1'b1;
    a = ecnt + 1;
    q8.push_back('{resp: (inv ? ~pat : pat), done_e: a + 17});
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      se_v[c]   = se8;
      busy_v[c] = busy8;
      if (c <= 8) si_v[8 - c] = si8;
      if (c >= 10 && c <= 17) si_unl = si_unl | si8;
      start8 = (c == pulse_a) || (c == pulse_b);
    end
    start8 = 1'b0;
    @(negedge clk);
    for (int c = 0; c <= 18; c++) begin
      se_exp[c]   = ((c >= 1) && (c <= 8)) || ((c >= 10) && (c <= 17));
      busy_exp[c] = (c >= 1) && (c <= 17);
    end
    check("seq8_se_profile", 64'(se_v), 64'(se_exp));
    check("seq8_busy_profile", 64'(busy_v), 64'(busy_exp));
    check("seq8_si_load_order", 64'(si_v), 64'(pat));
    check("seq8_si_unload_zero", 64'(si_unl), 64'd0);
  endtask

  // START held high: back-to-back sequences with DONE at cycles 18 and 37.
  task automatic held8(input logic [7:0] pat, input logic inv);
    int a;
    inv8   = inv;
    pat8   = pat;
    start8 = 1'b1;
    a = ecnt + 1;
    q8.push_back('{resp: (inv ? ~pat : pat), done_e: a + 17});
    q8.push_back('{resp: (inv ? ~pat : pat), done_e: a + 36});
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (t == 19) check("held_idle_gap_busy", 64'(busy8), 64'd0);
      if (t == 20) begin
        check("held_reaccept_busy", 64'(busy8), 64'd1);
        start8 = 1'b0;
      end
    end
  endtask

  // Reset asserted in cycle 10 (UNLOAD); outputs cleared on the next cycle.
  task automatic rst_mid8(input logic [7:0] pat);
    inv8   = 1'b1;
    pat8   = pat;
    start8 = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (c == 10) rst = 1'b1;
      if (c == 11) begin
        check("rst_mid_se", 64'(se8), 64'd0);
        check("rst_mid_si", 64'(si8), 64'd0);
        check("rst_mid_busy", 64'(busy8), 64'd0);
        check("rst_mid_done", 64'(done8), 64'd0);
        check("rst_mid_resp", 64'(resp8), 64'd0);
        rst = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  // One 2-flop sequence: DONE expected at cycle 6.
  task automatic seq2(input logic [1:0] pat, input logic inv);
    int a;
    inv2   = inv;
    pat2   = pat;
    start2 = 1'b1;
    a = ecnt + 1;
    q2.push_back('{resp: {6'b0, (inv ? ~pat : pat)}, done_e: a + 5});
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start2 = 1'b0;
    end
  endtask

  initial begin
    rst    = 1'b1;
    start8 = 1'b0;
    start2 = 1'b0;
    pat8   = '0;
    pat2   = '0;
    repeat (2) @(negedge clk);
    check("reset_se8", 64'(se8), 64'd0);
    check("reset_si8", 64'(si8), 64'd0);
    check("reset_busy8", 64'(busy8), 64'd0);
    check("reset_done8", 64'(done8), 64'd0);
    check("reset_resp8", 64'(resp8), 64'd0);
    check("reset_se2", 64'(se2), 64'd0);
    check("reset_resp2", 64'(resp2), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    seq8(8'hA5, 1'b1, 0, 0);   // inverting capture -> 8'h5A
    seq8(8'h81, 1'b0, 0, 0);   // holding capture   -> 8'h81
    seq8(8'hA5, 1'b1, 3, 17);  // extra START pulses while busy are ignored
    held8(8'h3C, 1'b1);        // DONE at 18 and 37, both 8'hC3
    rst_mid8(8'h96);           // abort in UNLOAD, no DONE
    seq8(8'h96, 1'b1, 0, 0);   // fresh run after abort -> 8'h69
    seq8(8'hFF, 1'b1, 0, 0);   // all-ones  -> 8'h00
    seq8(8'h00, 1'b1, 0, 0);   // all-zeros -> 8'hFF, back-to-back
    seq8(8'hFF, 1'b0, 0, 0);   // all-ones held -> 8'hFF

    seq2(2'b10, 1'b1);         // -> 2'b01
    seq2(2'b01, 1'b0);         // -> 2'b01

    repeat (5) @(negedge clk);
    check("dut8_all_done_seen", 64'(q8.size()), 64'd0);
    check("dut2_all_done_seen", 64'(q2.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Sequential controller that drives the SE/SI pins of a serial chain of scan flip-flops (sdffq-class cells) and collects the chain's SO output. It loads a parallel test pattern into the chain, pulses one functional capture clock, then unloads the captured response back into a parallel register. It sits directly upstream of the scan flops: every SE and SI bit the chain sees comes from this block, and the last flop's Q returns to it as SO.

## Interface
Parameters:
- CHAIN_LEN, default 8: number of scan flops in the chain (N); legal range 2..64.
- CNT_W, default $clog2(CHAIN_LEN): shift counter width; derived, never overridden.

Ports:
- CLK  input  1  Rising-edge clock, shared with the scan chain.
- RST  input  1  Synchronous, active-high reset; one clock, same clock as the chain.
- START  input  1  Request to run one load/capture/unload sequence; sampled only in IDLE.
- PAT  input  CHAIN_LEN  Pattern to load; sampled on the edge that accepts START.
- SE  output  1  Scan enable to every chain flop.
- SI  output  1  Serial data into chain flop 0.
- SO  input  1  Q of chain flop N-1.
- BUSY  output  1  High from the accepting edge until DONE.
- DONE  output  1  One-cycle pulse when RESP is valid.
- RESP  output  CHAIN_LEN  Captured response; RESP[k] = value captured by chain flop k.

## Operation
- States: IDLE, LOAD, CAPTURE, UNLOAD, FINISH.
- IDLE: SE=0, SI=0, BUSY=0. START=1 latches PAT into the shift register, clears the counter, and moves to LOAD.
- LOAD: SE=1. SI presents shift-register bits MSB first, so PAT[N-1] is shifted first. After N edges, chain flop k holds PAT[k]. The counter increments each cycle; LOAD exits to CAPTURE when the counter reaches N-1.
- CAPTURE: SE=0, SI=0 for exactly one cycle, so each flop samples its functional D. Then go to UNLOAD with the counter cleared.
- UNLOAD: SE=1, SI=0 as padding. On each edge SO is shifted into the response register, so RESP ends as RESP[N-1-j] = SO sampled in unload cycle j. UNLOAD exits after N cycles.
- FINISH: DONE=1, BUSY=0, SE=0 for one cycle, then IDLE.
- RESP holds until the next accepted START, then keeps updating during UNLOAD. DONE marks the only cycle at which RESP is guaranteed final.
- START while BUSY: ignored, no queuing. START held high in FINISH or IDLE: a new sequence begins on the next IDLE edge.
- Reset values: state=IDLE, SE=0, SI=0, BUSY=0, DONE=0, RESP=0, counter=0.
- Reset mid-sequence: all of the above on the next edge. Chain contents are undefined, and no DONE is emitted.

## Timing
- Cycle 0: the edge that accepts START.
- Cycles 1..N: LOAD, SE=1.
- Cycle N+1: CAPTURE, SE=0.
- Cycles N+2..2N+1: UNLOAD, SE=1.
- Cycle 2N+2: DONE=1.
- Total latency from START acceptance to DONE: 2N+2 cycles. The earliest next START acceptance is cycle 2N+3.
- SE and SI are registered outputs with no combinational path from START or SO. The chain sees them one edge after state entry; the counter accounts for this.
- SO is sampled on the same edge at which the chain shifts, which is the pre-shift value of flop N-1.
- BUSY rises on the cycle after the accepting edge and falls with DONE high.

## Structure
- Shared package `scan_ctrl_pkg`: state enum (IDLE, LOAD, CAPTURE, UNLOAD, FINISH) and the CHAIN_LEN range-check constants.
- One sub-module, `scan_shift_reg`: a CHAIN_LEN-bit parallel-load shift register with serial out (MSB) and serial in (LSB). Instantiate it twice, once for the pattern and once for the response.
- The FSM and counter live in the top module.

## Test plan
Benches use N=8 with a behavioural chain of 8 scan flops (mux: SE ? SI : D).
- Functional D of flop k = ~Q[k]; PAT=8'hA5 -> DONE at cycle 18, RESP=8'h5A.
- Functional D tied to Q, i.e. capture holds; PAT=8'h81 -> RESP=8'h81, SE low for exactly one cycle (cycle 9).
- START pulsed again at cycles 3 and 17 -> ignored, exactly one DONE at cycle 18. START held high continuously -> DONE at 18 and 37.
- RST asserted at cycle 10, mid-UNLOAD -> next cycle SE=0, BUSY=0, RESP=0, no DONE. A fresh START afterwards completes normally.
- N=2 build with PAT=2'b10 and inverting D -> DONE at cycle 6, RESP=2'b01.
- Edge check: PAT=all-ones then all-zeros back-to-back -> RESP correct for each. SI stays 0 throughout UNLOAD.
